// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// md_issue_ctrl: issues HI/LO mult/div ops for one cycle, shadows unit busy
// Revision: 1.0
// ---------------------------------------------------------------------------
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic        d_valid,
  input  logic [7:0]  d_md_op,
  input  logic [7:0]  md_busy_i,
  input  logic        md_start_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [7:0]  md_op_o,
  output logic        stall_d,
  output logic [31:0] mf_data_o,
  output logic        mf_valid_o,
  output logic        err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MWAIT = 2'd1;
  localparam logic [1:0] S_DWAIT = 2'd2;

  localparam logic [7:0] C_MULT_LAT = 8'(MULT_LAT);
  localparam logic [7:0] C_DIV_LAT  = 8'(DIV_LAT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  md_op_q, md_op_d;
  logic [31:0] mf_data_q, mf_data_d;
  logic        mf_valid_q, mf_valid_d;
  logic        err_q, err_d;

  logic w_d_start, w_d_mt, w_d_mf, w_d_md;
  logic w_q_start, w_q_mult, w_q_div;
  logic w_blocked, w_mismatch;

  assign w_d_start = (d_md_op >= 8'd24) && (d_md_op <= 8'd27);
  assign w_d_mt    = (d_md_op == 8'd28) || (d_md_op == 8'd29);
  assign w_d_mf    = (d_md_op == 8'd30) || (d_md_op == 8'd31);
  assign w_d_md    = w_d_start | w_d_mt | w_d_mf;

  assign w_q_mult  = (md_op_q == 8'd24) || (md_op_q == 8'd25);
  assign w_q_div   = (md_op_q == 8'd26) || (md_op_q == 8'd27);
  assign w_q_start = w_q_mult | w_q_div;

  // A START still sitting in the ALUop slot blocks HI/LO access before the FSM has left IDLE.
  assign w_blocked = (state_q != S_IDLE) | w_q_start;
  assign stall_d   = ~reset & d_valid & w_d_md & w_blocked;

  assign w_mismatch = ((state_q != S_IDLE) && (cnt_q > 8'd1) && (md_busy_i == 8'd0))
                    | ((state_q == S_IDLE) && (md_busy_i != 8'd0))
                    | (md_start_i != w_q_start);

  always_comb begin
    md_op_d = 8'd0;
    if (d_valid && (w_d_start || w_d_mt) && !stall_d && !int_req) begin
      md_op_d = d_md_op;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // An interrupt on the issue edge cancels the op; the unit ignores it too.
        if (!int_req && w_q_mult) begin
          state_d = S_MWAIT;
          cnt_d   = C_MULT_LAT;
        end else if (!int_req && w_q_div) begin
          state_d = S_DWAIT;
          cnt_d   = C_DIV_LAT;
        end
      end
      S_MWAIT, S_DWAIT: begin
        if (cnt_q > 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    mf_valid_d = d_valid & w_d_mf & ~stall_d;
    mf_data_d  = mf_data_q;
    if (mf_valid_d) begin
      mf_data_d = (d_md_op == 8'd30) ? hi_i : lo_i;
    end

    err_d = err_q | w_mismatch;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      md_op_q    <= 8'd0;
      mf_data_q  <= 32'd0;
      mf_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_op_q    <= md_op_d;
      mf_data_q  <= mf_data_d;
      mf_valid_q <= mf_valid_d;
      err_q      <= err_d;
    end
  end

  assign md_op_o    = md_op_q;
  assign mf_data_o  = mf_data_q;
  assign mf_valid_o = mf_valid_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_md_issue_ctrl: table-driven bench with a behavioural HI/LO unit model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_md_issue_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset, int_req, d_valid;
  logic [7:0]  d_md_op;
  logic [7:0]  md_busy_i;
  logic        md_start_i;
  logic [31:0] hi_i, lo_i;
  logic [7:0]  md_op_o;
  logic        stall_d;
  logic [31:0] mf_data_o;
  logic        mf_valid_o;
  logic        err_o;

  logic [31:0] op_a, op_b;
  logic        force_busy0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .int_req(int_req), .d_valid(d_valid),
    .d_md_op(d_md_op), .md_busy_i(md_busy_i), .md_start_i(md_start_i),
    .hi_i(hi_i), .lo_i(lo_i), .md_op_o(md_op_o), .stall_d(stall_d),
    .mf_data_o(mf_data_o), .mf_valid_o(mf_valid_o), .err_o(err_o)
  );

  // Behavioural unit: operands travel with the op into E; result lands LAT edges after issue.
  logic [7:0]  u_busy;
  logic [31:0] u_hi, u_lo, u_a, u_b, p_hi, p_lo;
  logic        u_start;

  function automatic logic [63:0] md_result(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      8'd24: begin sp = 64'(sa) * 64'(sb); return sp; end
      8'd25: return {32'd0, a} * {32'd0, b};
      8'd26: if (b == 32'd0) return 64'd0; else return {32'(sa % sb), 32'(sa / sb)};
      8'd27: if (b == 32'd0) return 64'd0; else return {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  assign u_start    = (md_op_o >= 8'd24) && (md_op_o <= 8'd27);
  assign md_start_i = u_start;
  assign md_busy_i  = force_busy0 ? 8'd0 : u_busy;
  assign hi_i       = u_hi;
  assign lo_i       = u_lo;

  always @(posedge clk) begin
    logic [63:0] r;
    if (reset) begin
      u_busy <= 8'd0; u_hi <= 32'd0; u_lo <= 32'd0;
      u_a <= 32'd0; u_b <= 32'd0; p_hi <= 32'd0; p_lo <= 32'd0;
    end else begin
      u_a <= op_a;
      u_b <= op_b;
      if (u_busy != 8'd0) begin
        u_busy <= u_busy - 8'd1;
        if (u_busy == 8'd1) begin
          u_hi <= p_hi;
          u_lo <= p_lo;
        end
      end else if (u_start && !int_req) begin
        r = md_result(md_op_o, u_a, u_b);
        p_hi <= r[63:32];
        p_lo <= r[31:0];
        u_busy <= (md_op_o <= 8'd25) ? 8'(MULT_LAT) : 8'(DIV_LAT);
      end
      if (md_op_o == 8'd28 && !int_req) u_hi <= u_a;
      if (md_op_o == 8'd29 && !int_req) u_lo <= u_a;
    end
  end

  typedef struct {
    logic        rst, irq, v;
    logic [7:0]  op;
    logic [31:0] a, b;
    logic        e_stall;
    logic [7:0]  e_op;
    logic        e_mfv;
    logic [31:0] e_mfd;
    logic        chk_d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic irq, input logic v, input logic [7:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic st,
                     input logic [7:0] eop, input logic emv, input logic [31:0] emd, input logic cd);
    vec_t t;
    t.rst = rst; t.irq = irq; t.v = v; t.op = op; t.a = a; t.b = b;
    t.e_stall = st; t.e_op = eop; t.e_mfv = emv; t.e_mfd = emd; t.chk_d = cd;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; int_req = 1'b0; d_valid = 1'b0; d_md_op = 8'd0;
    op_a = 32'd0; op_b = 32'd0; force_busy0 = 1'b0;

    // reset holds everything quiet even with a mult presented
    add(1,0,1,24,0,0, 0,0,0,0,1);
    add(1,0,1,24,0,0, 0,0,0,0,1);
    // signed mult -1*2, mflo stalls issue cycle + MULT_LAT cycles
    add(0,0,1,24,32'hFFFFFFFF,2, 0,24,0,0,1);
    for (int k = 0; k < 6; k++) add(0,0,1,31,0,0, 1,0,0,0,1);
    add(0,0,1,31,0,0, 0,0,1,32'hFFFFFFFE,1);
    add(0,0,1,30,0,0, 0,0,1,32'hFFFFFFFF,1);
    // divu 7/2, mfhi stalls 11 cycles
    add(0,0,1,27,7,2, 0,27,0,32'hFFFFFFFF,1);
    for (int k = 0; k < 11; k++) add(0,0,1,30,0,0, 1,0,0,32'hFFFFFFFF,1);
    add(0,0,1,30,0,0, 0,0,1,1,1);
    add(0,0,1,31,0,0, 0,0,1,3,1);
    // div cancelled by int_req in its issue cycle: LO untouched
    add(0,0,1,26,100,7, 0,26,0,3,1);
    add(0,1,1,31,0,0, 1,0,0,3,1);
    add(0,0,1,31,0,0, 0,0,1,3,1);
    // mtlo, then mflo while mtlo occupies the slot (not blocked), then mflo sees new LO
    add(0,0,1,29,32'h1234,0, 0,29,0,3,1);
    add(0,0,1,31,0,0, 0,0,1,0,0);
    add(0,0,1,31,0,0, 0,0,1,32'h1234,1);
    // back-to-back STARTs: second waits for IDLE
    add(0,0,1,24,3,4, 0,24,0,32'h1234,1);
    for (int k = 0; k < 6; k++) add(0,0,1,25,5,6, 1,0,0,32'h1234,1);
    add(0,0,1,25,5,6, 0,25,0,32'h1234,1);
    add(0,0,0,0,0,0, 0,0,0,32'h1234,1);

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; int_req = vecs[i].irq; d_valid = vecs[i].v;
      d_md_op = vecs[i].op; op_a = vecs[i].a; op_b = vecs[i].b;
      #1;
      chk($sformatf("v%0d.stall", i), 32'(stall_d), 32'(vecs[i].e_stall));
      tick();
      chk($sformatf("v%0d.md_op", i), 32'(md_op_o), 32'(vecs[i].e_op));
      chk($sformatf("v%0d.mf_valid", i), 32'(mf_valid_o), 32'(vecs[i].e_mfv));
      if (vecs[i].chk_d) chk($sformatf("v%0d.mf_data", i), mf_data_o, vecs[i].e_mfd);
      chk($sformatf("v%0d.err", i), 32'(err_o), 32'd0);
    end

    // busy forced low at cnt=3 in MWAIT sets a sticky error
    reset = 1'b1; int_req = 1'b0; d_valid = 1'b0; d_md_op = 8'd0; op_a = 32'd0; op_b = 32'd0;
    tick(); tick();
    reset = 1'b0; d_valid = 1'b1; d_md_op = 8'd24;
    tick();
    d_valid = 1'b0; d_md_op = 8'd0;
    tick(); tick(); tick();
    chk("err_before_force", 32'(err_o), 32'd0);
    force_busy0 = 1'b1;
    tick();
    chk("err_set", 32'(err_o), 32'd1);
    force_busy0 = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("err_sticky", 32'(err_o), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("err_cleared", 32'(err_o), 32'd0);

    // reset in the middle of a divide
    d_valid = 1'b1; d_md_op = 8'd26; op_a = 32'd9; op_b = 32'd3;
    tick();
    d_md_op = 8'd31; op_a = 32'd0; op_b = 32'd0;
    #1;
    chk("mid_stall_slot", 32'(stall_d), 32'd1);
    tick(); tick();
    chk("mid_stall_dwait", 32'(stall_d), 32'd1);
    reset = 1'b1;
    #1;
    chk("stall_in_reset", 32'(stall_d), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_reset_stall", 32'(stall_d), 32'd0);
    chk("post_reset_md_op", 32'(md_op_o), 32'd0);
    tick();
    chk("post_reset_mfv", 32'(mf_valid_o), 32'd1);
    chk("post_reset_mfd", mf_data_o, 32'd0);
    chk("post_reset_err", 32'(err_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
